// File: rtl/blu_pkg.sv
// Shared constants and stage types for the Dilithium butterfly cores.
// Coefficients are 23 bits wide, and all arithmetic is modulo Q = 8380417.
package blu_pkg;

    localparam int          COEF_W   = 23;
    localparam logic [22:0] Q        = 23'd8380417;
    localparam logic [31:0] QINV     = 32'd58728449;
    localparam logic [22:0] MONT_ONE = 23'd4193792;

    typedef logic [COEF_W-1:0] coef_t;

    // One pipeline slot. The p and m fields feed the Montgomery reduction,
    // and s rides alongside it unchanged.
    typedef struct packed {
        logic        valid;
        coef_t       s;
        logic [45:0] p;
        logic [31:0] m;
        coef_t       zeta;
    } stage_t;

endpackage

// File: rtl/mont_reduce.sv
// Two-stage Montgomery reduction: t = p * 2^-32 mod Q, returned in [0,Q).
// The s field and the valid bit pass through alongside the product.
module mont_reduce
    import blu_pkg::*;
#(
    parameter coef_t       MOD_Q    = Q,
    parameter logic [31:0] MOD_QINV = QINV
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   en_i,
    input  stage_t stage_i,
    output logic   valid_o,
    output coef_t  s_o,
    output coef_t  t_o
);

    stage_t      r_s3;
    logic        r_valid4;
    coef_t       r_s4;
    coef_t       r_t4;

    logic [31:0] w_m;
    logic [63:0] w_mq;
    logic [63:0] w_diff;
    logic [31:0] w_t;
    logic [31:0] w_tFix;
    logic        w_unused;

    assign w_m = stage_i.p[31:0] * MOD_QINV;

    // The low 32 bits of p - m*Q are zero by construction.
    // The upper half is the signed quotient, which lies in (-Q, Q).
    assign w_mq     = 64'(r_s3.m) * 64'(MOD_Q);
    assign w_diff   = 64'(r_s3.p) - w_mq;
    assign w_t      = w_diff[63:32];
    assign w_tFix   = w_t[31] ? (w_t + 32'(MOD_Q)) : w_t;
    assign w_unused = ^{w_diff[31:0], w_tFix[31:23], r_s3.zeta};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_s3     <= '0;
            r_valid4 <= 1'b0;
            r_s4     <= '0;
            r_t4     <= '0;
        end else if (en_i) begin
            r_s3       <= stage_i;
            r_s3.m     <= w_m;
            r_valid4   <= r_s3.valid;
            r_s4       <= r_s3.s;
            r_t4       <= w_tFix[22:0];
        end
    end

    assign valid_o = r_valid4;
    assign s_o     = r_s4;
    assign t_o     = r_t4;

endmodule

// File: rtl/gs_inv_butterfly.sv
// Gentleman-Sande inverse butterfly: a' = a + b, b' = (a - b) * zeta * 2^-32, all mod Q.
// It has four pipeline stages and a single global stall, driven by the output handshake.
module gs_inv_butterfly #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [22:0] Q          = blu_pkg::Q,
    parameter logic [31:0] QINV       = blu_pkg::QINV
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data1_i,
    input  logic [DATA_WIDTH-1:0] data2_i,
    input  logic [DATA_WIDTH-1:0] zeta_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data1_o,
    output logic [DATA_WIDTH-1:0] data2_o
);

    localparam int CW = blu_pkg::COEF_W;

    logic             w_en;
    logic [CW-1:0]    w_a;
    logic [CW-1:0]    w_b;
    logic [CW-1:0]    w_zeta;
    logic [CW:0]      w_sum;
    logic [CW:0]      w_sumRed;
    logic [CW:0]      w_dif;
    logic [CW:0]      w_difRed;
    logic             w_valid4;
    blu_pkg::coef_t   w_s4;
    blu_pkg::coef_t   w_t4;
    logic             w_unused;

    logic             r_valid1;
    blu_pkg::coef_t   r_s1;
    blu_pkg::coef_t   r_d1;
    blu_pkg::coef_t   r_zeta1;
    blu_pkg::stage_t  r_s2;

    // Every stage moves together. A stalled output freezes the whole pipe.
    assign w_en    = !w_valid4 || ready_i;
    assign ready_o = w_en;

    assign w_a    = data1_i[CW-1:0];
    assign w_b    = data2_i[CW-1:0];
    assign w_zeta = zeta_i[CW-1:0];

    assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
    assign w_sumRed = (w_sum >= {1'b0, Q}) ? (w_sum - {1'b0, Q}) : w_sum;
    assign w_dif    = {1'b0, w_a} - {1'b0, w_b};
    assign w_difRed = w_dif[CW] ? (w_dif + {1'b0, Q}) : w_dif;

    assign w_unused = ^{data1_i[DATA_WIDTH-1:CW], data2_i[DATA_WIDTH-1:CW],
                        zeta_i[DATA_WIDTH-1:CW], w_sumRed[CW], w_difRed[CW]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_valid1 <= 1'b0;
            r_s1     <= '0;
            r_d1     <= '0;
            r_zeta1  <= '0;
            r_s2     <= '0;
        end else if (w_en) begin
            r_valid1 <= valid_i;
            if (valid_i) begin
                r_s1    <= w_sumRed[CW-1:0];
                r_d1    <= w_difRed[CW-1:0];
                r_zeta1 <= w_zeta;
            end
            r_s2.valid <= r_valid1;
            r_s2.s     <= r_s1;
            r_s2.p     <= 46'(r_d1) * 46'(r_zeta1);
            r_s2.m     <= '0;
            r_s2.zeta  <= r_zeta1;
        end
    end

    mont_reduce #(
        .MOD_Q    (Q),
        .MOD_QINV (QINV)
    ) u_mont (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (w_en),
        .stage_i (r_s2),
        .valid_o (w_valid4),
        .s_o     (w_s4),
        .t_o     (w_t4)
    );

    assign valid_o = w_valid4;
    assign data1_o = {{(DATA_WIDTH-CW){1'b0}}, w_s4};
    assign data2_o = {{(DATA_WIDTH-CW){1'b0}}, w_t4};

endmodule
